// File: rtl/contador_regressivo_99.sv
// Two-digit BCD countdown timer (99..00) with prescaler, hold, done pulse
// and active-low 7-segment outputs. All state updates on the falling clock edge.
module contador_regressivo_99 #(
    parameter int PRESCALE = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] d_tens,
    input  logic [3:0] d_units,
    input  logic       start,
    input  logic       hold,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       zero,
    output logic       done,
    output logic       busy,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_units,
    output logic [1:0] dbg_state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 blanks the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign zero      = (tens == 4'd0) && (units == 4'd0);
    assign seg_tens  = seg7(tens);
    assign seg_units = seg7(units);
    assign dbg_state = state;

    // Priority: reset > load > start > hold > count.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            tens  <= 4'd0;
            units <= 4'd0;
            presc <= '0;
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                tens  <= clamp9(d_tens);
                units <= clamp9(d_units);
                presc <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start && state == IDLE) begin
                if (zero) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    state <= RUN;
                    presc <= '0;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (hold) begin
                            state <= PAUSE;
                        end else if (presc == P_LAST) begin
                            presc <= '0;
                            if (units != 4'd0) begin
                                units <= units - 4'd1;
                            end else begin
                                units <= 4'd9;
                                tens  <= tens - 4'd1;
                            end
                            // RUN is only entered with a nonzero count, so 01 is the last step.
                            if (tens == 4'd0 && units == 4'd1) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (!hold) state <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_contador_regressivo_99.sv
// Bench for the BCD countdown timer: two instances (PRESCALE 1 and 4) share
// inputs and are compared every cycle against an integer-count model.
module tb_contador_regressivo_99;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] d_tens = 4'd0;
    logic [3:0] d_units = 4'd0;

    logic [3:0] tens1, units1, tens4, units4;
    logic       zero1, done1, busy1, zero4, done4, busy4;
    logic [6:0] seg_tens1, seg_units1, seg_tens4, seg_units4;
    logic [1:0] dbg_state1, dbg_state4;

    int checks = 0;
    int errors = 0;

    contador_regressivo_99 #(.PRESCALE(1)) dut1 (
        .clock(clock), .reset(reset), .load(load), .d_tens(d_tens), .d_units(d_units),
        .start(start), .hold(hold), .tens(tens1), .units(units1), .zero(zero1),
        .done(done1), .busy(busy1), .seg_tens(seg_tens1), .seg_units(seg_units1),
        .dbg_state(dbg_state1)
    );

    contador_regressivo_99 #(.PRESCALE(4)) dut4 (
        .clock(clock), .reset(reset), .load(load), .d_tens(d_tens), .d_units(d_units),
        .start(start), .hold(hold), .tens(tens4), .units(units4), .zero(zero4),
        .done(done4), .busy(busy4), .seg_tens(seg_tens4), .seg_units(seg_units4),
        .dbg_state(dbg_state4)
    );

    // Clock / reset block: falling edges at 10,20,...; inputs change 2 after each rising edge.
    always #5 clock = ~clock;

    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
    end

    // Model: count held as a plain integer 0..99; phase counts edges toward the next step.
    // st: 0 idle, 1 running, 2 paused, 3 finished.
    typedef struct {
        int v;
        int ph;
        int st;
        bit dn;
    } mdl_t;

    mdl_t m1 = '{0, 0, 0, 1'b0};
    mdl_t m4 = '{0, 0, 0, 1'b0};

    function automatic int clamp(input int x);
        return (x > 9) ? 9 : x;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int p);
        mdl_t n = m;
        n.dn = 1'b0;
        if (load) begin
            n.v  = clamp(int'(d_tens)) * 10 + clamp(int'(d_units));
            n.ph = 0;
            n.st = 0;
        end else if (start && m.st == 0) begin
            if (m.v == 0) begin
                n.st = 3;
                n.dn = 1'b1;
            end else begin
                n.st = 1;
                n.ph = 0;
            end
        end else if (m.st == 1) begin
            if (hold) begin
                n.st = 2;
            end else if (m.ph == p - 1) begin
                n.ph = 0;
                n.v  = (m.v > 0) ? m.v - 1 : 0;
                if (n.v == 0) begin
                    n.st = 3;
                    n.dn = 1'b1;
                end
            end else begin
                n.ph = m.ph + 1;
            end
        end else if (m.st == 2 && !hold) begin
            n.st = 1;
        end
        return n;
    endfunction

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            m1 <= '{0, 0, 0, 1'b0};
            m4 <= '{0, 0, 0, 1'b0};
        end else begin
            m1 <= step(m1, 1);
            m4 <= step(m4, 4);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input mdl_t m, input logic [3:0] t, input logic [3:0] u,
                           input logic z, input logic dn, input logic b,
                           input logic [6:0] st, input logic [6:0] su);
        chk({tag, ".tens"}, int'(t), m.v / 10);
        chk({tag, ".units"}, int'(u), m.v % 10);
        chk({tag, ".zero"}, int'(z), (m.v == 0) ? 1 : 0);
        chk({tag, ".done"}, int'(dn), int'(m.dn));
        chk({tag, ".busy"}, int'(b), (m.st == 1 || m.st == 2) ? 1 : 0);
        chk({tag, ".seg_tens"}, int'(st), int'(seg_tab[m.v / 10]));
        chk({tag, ".seg_units"}, int'(su), int'(seg_tab[m.v % 10]));
    endtask

    // Compare process: rising edge, midway between falling-edge updates.
    always @(posedge clock) begin
        cmp_dut("p1", m1, tens1, units1, zero1, done1, busy1, seg_tens1, seg_units1);
        cmp_dut("p4", m4, tens4, units4, zero4, done4, busy4, seg_tens4, seg_units4);
    end

    // Driver tasks: each cyc() spans exactly one falling edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic do_load(input int t, input int u);
        d_tens  = 4'(t);
        d_units = 4'(u);
        load    = 1'b1;
        cyc();
        load    = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst.tens", int'(tens1), 0);
        chk("rst.busy", int'(busy1), 0);
        chk("rst.zero", int'(zero1), 1);
        chk("rst.seg_units", int'(seg_units1), 7'b1000000);
        cyc();
        reset = 1'b1;
        cyc();

        // Full countdown 25 -> 00 at one step per edge.
        do_load(2, 5);
        do_start();
        repeat (24) cyc();
        chk("cd.units_01", int'(units1), 1);
        chk("cd.busy_01", int'(busy1), 1);
        cyc();
        chk("cd.done", int'(done1), 1);
        chk("cd.busy_end", int'(busy1), 0);
        chk("cd.seg_units", int'(seg_units1), 7'b1000000);
        cyc();
        chk("cd.done_drop", int'(done1), 0);

        // Borrow and clamp.
        do_load(1, 0);
        do_start();
        cyc();
        chk("brw.tens", int'(tens1), 0);
        chk("brw.seg_units", int'(seg_units1), 7'b0010000);
        do_load(12, 15);
        chk("clamp.tens", int'(tens1), 9);
        chk("clamp.units", int'(units1), 9);

        // Hold pauses the count.
        do_load(0, 5);
        do_start();
        repeat (2) cyc();
        hold = 1'b1;
        repeat (4) cyc();
        chk("hold.units", int'(units1), 3);
        chk("hold.busy", int'(busy1), 1);
        hold = 1'b0;
        cyc();
        chk("resume.units", int'(units1), 3);
        cyc();
        chk("resume.step", int'(units1), 2);
        repeat (3) cyc();

        // PRESCALE=4: steps every fourth edge, stops at 00.
        do_load(0, 2);
        do_start();
        repeat (3) cyc();
        chk("p4.hold_02", int'(units4), 2);
        cyc();
        chk("p4.edge4", int'(units4), 1);
        repeat (4) cyc();
        chk("p4.done", int'(done4), 1);
        repeat (5) cyc();
        chk("p4.nowrap", int'(tens4), 0);

        // Asynchronous reset while running at 37.
        do_load(3, 8);
        do_start();
        repeat (4) cyc();
        chk("p4.at37", int'(units4), 7);
        reset = 1'b0;
        #1;
        chk("arst.tens", int'(tens4), 0);
        chk("arst.units", int'(units4), 0);
        chk("arst.busy", int'(busy4), 0);
        #1 reset = 1'b1;
        cyc();
        chk("arst.idle", int'(busy4), 0);

        // Load aborts a run.
        do_load(2, 0);
        do_start();
        repeat (2) cyc();
        do_load(1, 5);
        chk("abort.units", int'(units1), 5);
        chk("abort.busy", int'(busy1), 0);

        // Start with 00, start in DONE, load+start together.
        do_load(0, 0);
        do_start();
        chk("z.done", int'(done1), 1);
        do_start();
        chk("z.again", int'(done1), 0);
        d_tens = 4'd4; d_units = 4'd2; load = 1'b1; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        cyc();
        chk("ls.busy", int'(busy1), 0);
        chk("ls.tens", int'(tens1), 4);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            load    = ($urandom_range(0, 24) == 0);
            start   = ($urandom_range(0, 7) == 0);
            hold    = ($urandom_range(0, 5) == 0);
            d_tens  = 4'($urandom_range(0, 15));
            d_units = 4'($urandom_range(0, 15));
            if (load && $urandom_range(0, 1) == 1) d_tens = 4'($urandom_range(0, 2));
            cyc();
        end
        load = 1'b0; start = 1'b0; hold = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_regressivo_99.md
Name: contador_regressivo_99

Overview:
- Two-digit BCD down-counter (countdown timer, 99..00), the counterpart to the team's mod-10 BCD up-counter.
- Loads a BCD start value, decrements once every PRESCALE clock edges while running, and stops at 00 with a one-cycle done pulse.
- Drives two active-low 7-segment displays directly. Sits between the board switches/keys and the display pins in the timer lab designs.

Parameters:
- PRESCALE, 1, number of active clock edges per decrement; legal range 1..65535. Internal prescaler width is sized to hold PRESCALE-1.

Ports:
- clock  input  1  system clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load strobe, sampled on the falling edge.
- d_tens  input  4  tens digit to load (BCD).
- d_units  input  4  units digit to load (BCD).
- start  input  1  synchronous start strobe.
- hold  input  1  level; freezes counting while high.
- tens  output  4  current tens digit (BCD).
- units  output  4  current units digit (BCD).
- zero  output  1  high when tens==0 and units==0.
- done  output  1  one-cycle pulse when the count reaches 00 by counting, or on start with 00.
- busy  output  1  high in RUN or PAUSE.
- seg_tens  output  7  active-low segments {g,f,e,d,c,b,a} for tens.
- seg_units  output  7  active-low segments {g,f,e,d,c,b,a} for units.

Behaviour:
- Reset (reset==0, asynchronous, overrides everything):
  - tens=units=0, prescaler=0, state=IDLE.
  - done=0, busy=0, zero=1, seg_tens=seg_units=7'b1000000 (digit 0).
- States: IDLE, RUN, PAUSE, DONE. All registered outputs change only on the falling edge of clock, or immediately on reset.
- Priority on each edge: reset > load > start > hold > count.
- load=1, in any state:
  - Captures d_tens/d_units; any digit >9 is clamped to 9.
  - prescaler=0, next state IDLE, done=0. Aborts a run in progress.
- start=1, in IDLE:
  - If the loaded value is 00: go to DONE and pulse done on that same edge.
  - Otherwise: go to RUN with prescaler=0.
- start in RUN, PAUSE or DONE: ignored.
- RUN:
  - If hold=1: go to PAUSE; count and prescaler are unchanged.
  - Else if prescaler==PRESCALE-1: prescaler=0 and decrement.
  - Else: prescaler+1.
- Decrement rules:
  - units>0: units-1.
  - units==0: units=9 and tens-1 (borrow).
  - If the new value is 00: state=DONE, done=1 on that edge.
  - The count never wraps below 00.
- PAUSE: hold=0 returns to RUN on the next edge, resuming the prescaler from its frozen value. Count and prescaler are frozen while in PAUSE.
- DONE: holds 00 and zero=1 until load. done is high for exactly one clock period after entry, then 0.
- busy=1 iff state is RUN or PAUSE. zero is combinational from the held digits.
- Segment decode (combinational from the held digits):
  - 0..9 use the standard active-low patterns, e.g. 0=1000000, 1=1111001, 8=0000000, 9=0010000.
  - Internal digits never exceed 9; the decoder default is all-off (1111111).
- Simultaneous load and start: load wins and start is ignored on that edge.
- Reset asserted mid-run: outputs are cleared immediately, without waiting for a clock edge. After reset release the block stays IDLE until load/start.
- Expected implementation size: about 150-250 lines (FSM, prescaler, BCD datapath, two decoders).

Test Plan:
1. PRESCALE=1: reset, load 25, start, run 25 falling edges -> count steps 25,24,...,00; done high for exactly 1 cycle at edge 25; busy falls at the same edge; zero=1; seg_units=1000000.
2. Borrow and clamp:
   - load 10, start, 1 decrement -> tens=0, units=9, seg_units=0010000.
   - load d_tens=4'hC, d_units=4'hF -> tens=9, units=9.
3. Hold: load 05, start, 2 decrements (03), hold=1 for 4 edges -> stays 03, busy=1; release -> 02 follows one edge after the return to RUN.
4. PRESCALE=4: load 02, start -> decrements on edges 4 and 8 after start; done pulses at edge 8; never reaches 99 (no wrap).
5. Reset mid-run at count 37 between clock edges -> tens=units=0 and busy=0 without a clock edge. Load 15 during RUN -> aborts to IDLE holding 15, no done pulse.
6. Corner cases:
   - Start with 00 loaded -> DONE next edge with a single done pulse.
   - A second start in DONE -> no pulse.
   - load+start on the same edge -> IDLE with the new value.
